// File: rtl/pzbcm_ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller: the pointer
// advance rule and the registered status flag bundle.
package pzbcm_ram_fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almost_full;
    logic full;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{empty: 1'b1, almost_full: 1'b0, full: 1'b0};

  // Depth need not be a power of two, so wrapping is an explicit compare.
  function automatic int unsigned advance_pointer(int unsigned pointer, int unsigned depth);
    return (pointer == depth - 1) ? 0 : pointer + 1;
  endfunction

endpackage

// File: rtl/pzbcm_ram_fifo_pointer.sv
// Wrapping RAM pointer: counts 0..DEPTH-1, advancing on i_advance and
// returning to zero on synchronous clear or asynchronous reset.
module pzbcm_ram_fifo_pointer
  import pzbcm_ram_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_pointer
);

  logic [WIDTH-1:0] pointer_d;
  logic [WIDTH-1:0] pointer_q;

  always_comb begin
    pointer_d = pointer_q;
    if (i_clr) begin
      pointer_d = '0;
    end else if (i_advance) begin
      pointer_d = WIDTH'(advance_pointer(32'(pointer_q), DEPTH));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pointer_q <= '0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

  assign o_pointer = pointer_q;

endmodule

// File: rtl/pzbcm_ram_fifo_controller.sv
// Pointer/flag controller turning a simple dual-port RAM into a synchronous FIFO.
// Optional sticky overflow/underflow detection: PZBCM_RAM_FIFO_CONTROLLER_ERROR_CHECK_EN.
module pzbcm_ram_fifo_controller
  import pzbcm_ram_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int THRESHOLD     = DEPTH,
  parameter int ADDRESS_WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1,
  parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_full,
  output logic [COUNT_WIDTH-1:0]   o_word_count,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic                     o_mea,
  output logic                     o_wea,
  output logic [ADDRESS_WIDTH-1:0] o_adra,
  output logic                     o_meb,
  output logic [ADDRESS_WIDTH-1:0] o_adrb
);

  logic                     push_ack;
  logic                     pop_ack;
  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [ADDRESS_WIDTH-1:0] read_pointer;
  logic [COUNT_WIDTH-1:0]   word_count_d;
  logic [COUNT_WIDTH-1:0]   word_count_q;
  fifo_status_t             status_d;
  fifo_status_t             status_q;

  // Gating on the registered flags lets a pop drain a full FIFO and a push fill an empty one.
  always_comb begin
    push_ack = i_push & ~status_q.full;
    pop_ack  = i_pop & ~status_q.empty;
  end

  pzbcm_ram_fifo_pointer #(.DEPTH(DEPTH), .WIDTH(ADDRESS_WIDTH)) u_write_pointer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_clr),
    .i_advance (push_ack),
    .o_pointer (write_pointer)
  );

  pzbcm_ram_fifo_pointer #(.DEPTH(DEPTH), .WIDTH(ADDRESS_WIDTH)) u_read_pointer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_clr),
    .i_advance (pop_ack),
    .o_pointer (read_pointer)
  );

  // Flags come from the next count so they are registered alongside it.
  always_comb begin
    word_count_d = word_count_q;
    if (i_clr) begin
      word_count_d = '0;
    end else if (push_ack && !pop_ack) begin
      word_count_d = word_count_q + COUNT_WIDTH'(1);
    end else if (pop_ack && !push_ack) begin
      word_count_d = word_count_q - COUNT_WIDTH'(1);
    end
    status_d.empty       = (word_count_d == '0);
    status_d.almost_full = (word_count_d >= COUNT_WIDTH'(THRESHOLD));
    status_d.full        = (word_count_d == COUNT_WIDTH'(DEPTH));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_count_q <= '0;
      status_q     <= STATUS_RESET;
    end else begin
      word_count_q <= word_count_d;
      status_q     <= status_d;
    end
  end

`ifdef PZBCM_RAM_FIFO_CONTROLLER_ERROR_CHECK_EN
  logic overflow_d;
  logic overflow_q;
  logic underflow_d;
  logic underflow_q;

  // Sticky until reset; a flush deliberately leaves them set.
  always_comb begin
    overflow_d  = overflow_q | (i_push & status_q.full);
    underflow_d = underflow_q | (i_pop & status_q.empty);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_empty       = status_q.empty;
  assign o_almost_full = status_q.almost_full;
  assign o_full        = status_q.full;
  assign o_word_count  = word_count_q;
  assign o_mea         = push_ack;
  assign o_wea         = push_ack;
  assign o_adra        = write_pointer;
  assign o_meb         = pop_ack;
  assign o_adrb        = read_pointer;

endmodule

// File: tb/tb_pzbcm_ram_fifo_controller.sv
// Directed bench for pzbcm_ram_fifo_controller: an 8-deep instance (THRESHOLD=5)
// and a 6-deep instance for non-power-of-two wrap, checked against a queue of predictions.
module tb_pzbcm_ram_fifo_controller;

  typedef struct {
    logic [31:0] empty;
    logic [31:0] afull;
    logic [31:0] full;
    logic [31:0] count;
    logic [31:0] adra;
    logic [31:0] adrb;
    logic [31:0] mea;
    logic [31:0] wea;
    logic [31:0] meb;
    logic [31:0] ovf;
    logic [31:0] unf;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  bit   in_push [2];
  bit   in_pop  [2];
  bit   in_clr  [2];

  logic       empty_a, afull_a, full_a, ovf_a, unf_a, mea_a, wea_a, meb_a;
  logic [3:0] cnt_a;
  logic [2:0] adra_a, adrb_a;
  logic       empty_b, afull_b, full_b, ovf_b, unf_b, mea_b, wea_b, meb_b;
  logic [2:0] cnt_b;
  logic [2:0] adra_b, adrb_b;

  int    depth   [2] = '{8, 6};
  int    thresh  [2] = '{5, 6};
  int    m_cnt   [2];
  int    m_wp    [2];
  int    m_rp    [2];
  int    m_ovf   [2];
  int    m_unf   [2];
  snap_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  string stepName = "reset";

  always #5 clk = ~clk;

  pzbcm_ram_fifo_controller #(.DEPTH(8), .THRESHOLD(5)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clr(in_clr[0]), .i_push(in_push[0]), .i_pop(in_pop[0]),
    .o_empty(empty_a), .o_almost_full(afull_a), .o_full(full_a), .o_word_count(cnt_a),
    .o_overflow(ovf_a), .o_underflow(unf_a), .o_mea(mea_a), .o_wea(wea_a),
    .o_adra(adra_a), .o_meb(meb_a), .o_adrb(adrb_a)
  );

  pzbcm_ram_fifo_controller #(.DEPTH(6)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clr(in_clr[1]), .i_push(in_push[1]), .i_pop(in_pop[1]),
    .o_empty(empty_b), .o_almost_full(afull_b), .o_full(full_b), .o_word_count(cnt_b),
    .o_overflow(ovf_b), .o_underflow(unf_b), .o_mea(mea_b), .o_wea(wea_b),
    .o_adra(adra_b), .o_meb(meb_b), .o_adrb(adrb_b)
  );

  function automatic snap_t observe(int idx);
    snap_t s;
    if (idx == 0) begin
      s = '{32'(empty_a), 32'(afull_a), 32'(full_a), 32'(cnt_a), 32'(adra_a), 32'(adrb_a),
            32'(mea_a), 32'(wea_a), 32'(meb_a), 32'(ovf_a), 32'(unf_a)};
    end else begin
      s = '{32'(empty_b), 32'(afull_b), 32'(full_b), 32'(cnt_b), 32'(adra_b), 32'(adrb_b),
            32'(mea_b), 32'(wea_b), 32'(meb_b), 32'(ovf_b), 32'(unf_b)};
    end
    return s;
  endfunction

  function automatic snap_t predict(int idx);
    snap_t s;
    int    acceptPush;
    int    acceptPop;
    acceptPush = (in_push[idx] && m_cnt[idx] < depth[idx]) ? 1 : 0;
    acceptPop  = (in_pop[idx] && m_cnt[idx] > 0) ? 1 : 0;
    s.empty = (m_cnt[idx] == 0) ? 1 : 0;
    s.afull = (m_cnt[idx] >= thresh[idx]) ? 1 : 0;
    s.full  = (m_cnt[idx] == depth[idx]) ? 1 : 0;
    s.count = m_cnt[idx];
    s.adra  = m_wp[idx];
    s.adrb  = m_rp[idx];
    s.mea   = acceptPush;
    s.wea   = acceptPush;
    s.meb   = acceptPop;
    s.ovf   = m_ovf[idx];
    s.unf   = m_unf[idx];
    return s;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_wp[i]  = 0;
      m_rp[i]  = 0;
      m_ovf[i] = 0;
      m_unf[i] = 0;
    end
  endfunction

  function automatic void modelStep(int idx, bit p, bit q, bit c);
    bit pushOk;
    bit popOk;
    pushOk = p && (m_cnt[idx] < depth[idx]);
    popOk  = q && (m_cnt[idx] > 0);
`ifdef PZBCM_RAM_FIFO_CONTROLLER_ERROR_CHECK_EN
    if (p && m_cnt[idx] == depth[idx]) m_ovf[idx] = 1;
    if (q && m_cnt[idx] == 0) m_unf[idx] = 1;
`endif
    if (c) begin
      m_cnt[idx] = 0;
      m_wp[idx]  = 0;
      m_rp[idx]  = 0;
    end else begin
      if (pushOk) m_wp[idx] = (m_wp[idx] + 1) % depth[idx];
      if (popOk) m_rp[idx] = (m_rp[idx] + 1) % depth[idx];
      m_cnt[idx] = m_cnt[idx] + (pushOk ? 1 : 0) - (popOk ? 1 : 0);
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s %s: observed %0d expected %0d", stepName, tag, obs, expv);
    end
  endtask

  task automatic checkOutput(int idx);
    snap_t e;
    snap_t o;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard: observed empty queue expected an entry", stepName);
      return;
    end
    e = sbq.pop_front();
    o = observe(idx);
    check("empty", o.empty, e.empty);
    check("almost_full", o.afull, e.afull);
    check("full", o.full, e.full);
    check("word_count", o.count, e.count);
    check("adra", o.adra, e.adra);
    check("adrb", o.adrb, e.adrb);
    check("mea", o.mea, e.mea);
    check("wea", o.wea, e.wea);
    check("meb", o.meb, e.meb);
    check("overflow", o.ovf, e.ovf);
    check("underflow", o.unf, e.unf);
  endtask

  // One clocked step: check strobes before the edge, state after it.
  task automatic applyStimulus(string name, int idx, bit p, bit q, bit c);
    stepName = name;
    @(negedge clk);
    in_push[idx] = p;
    in_pop[idx]  = q;
    in_clr[idx]  = c;
    #1;
    sbq.push_back(predict(idx));
    checkOutput(idx);
    modelStep(idx, p, q, c);
    sbq.push_back(predict(idx));
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_push[i] = 1'b0;
      in_pop[i]  = 1'b0;
      in_clr[i]  = 1'b0;
    end
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sbq.push_back(predict(0));
    checkOutput(0);
    sbq.push_back(predict(1));
    checkOutput(1);

    for (int i = 0; i < 8; i++) applyStimulus("fill", 0, 1'b1, 1'b0, 1'b0);
    applyStimulus("push_when_full", 0, 1'b1, 1'b0, 1'b0);
    applyStimulus("push_pop_full", 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus("drain", 0, 1'b0, 1'b1, 1'b0);
    applyStimulus("pop_when_empty", 0, 1'b0, 1'b1, 1'b0);
    applyStimulus("push_pop_empty", 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("refill", 0, 1'b1, 1'b0, 1'b0);
    applyStimulus("clear_with_push", 0, 1'b1, 1'b0, 1'b1);
    applyStimulus("after_clear", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("threshold_fill", 0, 1'b1, 1'b0, 1'b0);
    applyStimulus("threshold_pop", 0, 1'b0, 1'b1, 1'b0);
    applyStimulus("hold_four", 0, 1'b0, 1'b0, 1'b0);

    stepName = "async_reset";
    @(negedge clk);
    #1 rst = 1'b1;
    modelReset();
    #1;
    sbq.push_back(predict(0));
    checkOutput(0);
    #1 rst = 1'b0;
    applyStimulus("after_reset", 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) applyStimulus("d6_fill", 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("d6_drain", 1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("d6_wrap", 1, 1'b1, 1'b0, 1'b0);
    applyStimulus("d6_idle", 1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
